// File: rtl/tpu_mmio_seq_pkg.sv
// Shared constants, FSM state type and address helper for the TPU
// MMIO job sequencer.
package tpu_mmio_seq_pkg;

  localparam int unsigned A_BASE       = 32'h100;
  localparam int unsigned B_BASE       = 32'h200;
  localparam int unsigned C_BASE       = 32'h300;
  localparam int unsigned START_ADDR   = 32'h400;
  localparam int unsigned A_ROW_STRIDE = 8;
  localparam int unsigned C_ROW_STRIDE = 16;
  localparam int unsigned C_HI_OFS     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_C,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_READ,
    S_DRAIN
  } state_e;

  // Even k selects the low word of row k/2, odd k the high word.
  function automatic int unsigned c_addr(input int unsigned k);
    return C_BASE + (k >> 1) * C_ROW_STRIDE + (k & 1) * C_HI_OFS;
  endfunction

endpackage

// File: rtl/tpu_mmio_outbuf.sv
// One-entry valid/ready register holding a C word read back from
// the TPU until the sink accepts it.
module tpu_mmio_outbuf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/tpu_mmio_seq.sv
// MMIO initiator running one clear/load/start/wait/readback
// matrix-multiply job on the TPU slave port.
module tpu_mmio_seq
  import tpu_mmio_seq_pkg::*;
#(
  parameter int DIM         = 8,
  parameter int BITS_AB     = 8,
  parameter int BITS_C      = 16,
  parameter int DATAW       = 64,
  parameter int ADDRW       = 16,
  parameter int WAIT_CYCLES = 4 * DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             busy,
  output logic             done,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [DATAW-1:0] src_data,
  output logic             snk_valid,
  input  logic             snk_ready,
  output logic [DATAW-1:0] snk_data,
  output logic             mmio_r_w,
  output logic [ADDRW-1:0] mmio_addr,
  output logic [DATAW-1:0] mmio_wdata,
  input  logic [DATAW-1:0] mmio_rdata
);

  localparam int IW = $clog2(2 * DIM) + 1;
  localparam bit CFG_OK = (DIM / 2 * BITS_C == DATAW)
                       && (DIM * BITS_AB <= DATAW)
                       && (WAIT_CYCLES <= (1 << IW));

  if (!CFG_OK) begin : g_bad_cfg
    $error("tpu_mmio_seq: inconsistent DIM/BITS/DATAW/WAIT");
  end

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  logic rd_req;
  logic rd_ready;
  logic rd_fire;

  assign rd_req  = (state_q == S_READ);
  assign rd_fire = rd_req && rd_ready;

  tpu_mmio_outbuf #(
    .W (DATAW)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_req),
    .in_ready  (rd_ready),
    .in_data   (mmio_rdata),
    .out_valid (snk_valid),
    .out_ready (snk_ready),
    .out_data  (snk_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A go coinciding with the done pulse belongs to the old job.
        if (go && !done_q) begin
          state_d = S_CLR_C;
          idx_d   = '0;
        end
      end
      S_CLR_C: begin
        if (idx_q == IW'(2 * DIM - 1)) begin
          state_d = S_LOAD_A;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_LOAD_A: begin
        if (src_valid) begin
          if (idx_q == IW'(DIM - 1)) begin
            state_d = S_LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (src_valid) begin
          if (idx_q == IW'(DIM - 1)) begin
            state_d = S_START;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
        idx_d   = '0;
      end
      S_WAIT: begin
        if (idx_q == IW'(WAIT_CYCLES - 1)) begin
          state_d = S_READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_READ: begin
        if (rd_fire) begin
          if (idx_q == IW'(2 * DIM - 1)) begin
            state_d = S_DRAIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (snk_valid && snk_ready) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign src_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);

  always_comb begin
    mmio_r_w   = 1'b0;
    mmio_addr  = '0;
    mmio_wdata = '0;
    unique case (state_q)
      S_CLR_C: begin
        mmio_r_w  = 1'b1;
        mmio_addr = ADDRW'(c_addr(32'(idx_q)));
      end
      S_LOAD_A: begin
        mmio_r_w   = src_valid;
        mmio_addr  = ADDRW'(A_BASE + 32'(idx_q) * A_ROW_STRIDE);
        mmio_wdata = src_data;
      end
      S_LOAD_B: begin
        mmio_r_w   = src_valid;
        mmio_addr  = ADDRW'(B_BASE);
        mmio_wdata = src_data;
      end
      S_START: begin
        mmio_r_w  = 1'b1;
        mmio_addr = ADDRW'(START_ADDR);
      end
      S_READ: begin
        mmio_addr = ADDRW'(c_addr(32'(idx_q)));
      end
      default: begin
        mmio_r_w = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_mmio_seq.sv
// Bench for tpu_mmio_seq: behavioural TPU slave, scoreboard of
// golden C words, per-cycle bus trace for the unstalled job.
module tb_tpu_mmio_seq;

  localparam int DIM   = 8;
  localparam int DATAW = 64;
  localparam int ADDRW = 16;
  localparam int NW    = 2 * DIM;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             busy;
  logic             done;
  logic             src_valid;
  logic             src_ready;
  logic [DATAW-1:0] src_data;
  logic             snk_valid;
  logic             snk_ready;
  logic [DATAW-1:0] snk_data;
  logic             mmio_r_w;
  logic [ADDRW-1:0] mmio_addr;
  logic [DATAW-1:0] mmio_wdata;
  logic [DATAW-1:0] mmio_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATAW-1:0] exp_q[$];
  logic [DATAW-1:0] src_q[$];

  logic [7:0]  ma[DIM][DIM];
  logic [7:0]  mb[DIM][DIM];
  logic [7:0]  ta[DIM][DIM];
  logic [7:0]  tb[DIM][DIM];
  logic [15:0] tc[DIM][DIM];
  int          bcnt = 0;

  always #5 clk = ~clk;

  tpu_mmio_seq #(
    .DIM         (DIM),
    .BITS_AB     (8),
    .BITS_C      (16),
    .DATAW       (DATAW),
    .ADDRW       (ADDRW),
    .WAIT_CYCLES (4 * DIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .busy       (busy),
    .done       (done),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .snk_valid  (snk_valid),
    .snk_ready  (snk_ready),
    .snk_data   (snk_data),
    .mmio_r_w   (mmio_r_w),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata)
  );

  // Behavioural TPU slave: C accumulates A*B on each start write.
  function automatic logic [15:0] tdot(input int i, input int j);
    logic [15:0] s = '0;
    for (int k = 0; k < DIM; k++) s += 16'(ta[i][k]) * 16'(tb[k][j]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bcnt <= 0;
    end else if (mmio_r_w) begin
      if (mmio_addr >= 16'h100 && mmio_addr < 16'h140) begin
        for (int j = 0; j < DIM; j++)
          ta[int'((mmio_addr - 16'h100) >> 3)][j] <= mmio_wdata[j*8 +: 8];
      end else if (mmio_addr == 16'h200) begin
        for (int j = 0; j < DIM; j++)
          tb[bcnt % DIM][j] <= mmio_wdata[j*8 +: 8];
        bcnt <= bcnt + 1;
      end else if (mmio_addr >= 16'h300 && mmio_addr < 16'h380) begin
        for (int j = 0; j < DIM / 2; j++)
          tc[int'((mmio_addr - 16'h300) >> 4)][int'(mmio_addr[3]) * 4 + j]
            <= mmio_wdata[j*16 +: 16];
      end else if (mmio_addr == 16'h400) begin
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++)
            tc[i][j] <= tc[i][j] + tdot(i, j);
        bcnt <= 0;
      end
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_addr >= 16'h300 && mmio_addr < 16'h380) begin
      for (int j = 0; j < DIM / 2; j++)
        mmio_rdata[j*16 +: 16] =
          tc[int'((mmio_addr - 16'h300) >> 4)][int'(mmio_addr[3]) * 4 + j];
    end
  end

  function automatic logic [15:0] c_exp_addr(input int k);
    return 16'(16'h300 + (k >> 1) * 16 + (k & 1) * 8);
  endfunction

  // Operands, source beats and golden C words for one job.
  task automatic load_job(input int pat);
    logic [DATAW-1:0] w;
    logic [15:0]      s;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        if (pat == 0) begin
          ma[i][j] = (i == j) ? 8'd1 : 8'd0;
          mb[i][j] = 8'd1;
        end else begin
          ma[i][j] = 8'($urandom_range(0, 255));
          mb[i][j] = 8'($urandom_range(0, 255));
        end
      end
    src_q.delete();
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) w[j*8 +: 8] = ma[i][j];
      src_q.push_back(w);
    end
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) w[j*8 +: 8] = mb[i][j];
      src_q.push_back(w);
    end
    exp_q.delete();
    for (int i = 0; i < DIM; i++)
      for (int h = 0; h < 2; h++) begin
        for (int j = 0; j < DIM / 2; j++) begin
          s = '0;
          for (int k = 0; k < DIM; k++)
            s += 16'(ma[i][k]) * 16'(mb[k][h*4 + j]);
          w[j*16 +: 16] = s;
        end
        exp_q.push_back(w);
      end
  endtask

  task automatic run_job(input bit toggle, input int stall_at,
                         input int go_at, input int rst_at,
                         input bit trace, output int done_cyc);
    int               sbeat;
    int               beats;
    bit               holding;
    logic [DATAW-1:0] held;
    logic [DATAW-1:0] w;
    logic [15:0]      ea;
    logic [83:0]      act;
    logic [83:0]      exp;
    done_cyc = -1;
    sbeat    = 0;
    beats    = 0;
    holding  = 1'b0;
    held     = '0;
    @(negedge clk);
    go        = 1'b1;
    src_valid = 1'b0;
    snk_ready = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      go        = (cyc == go_at);
      src_valid = (src_q.size() > 0) && (!toggle || (cyc % 2 == 1));
      src_data  = (src_q.size() > 0) ? src_q[0] : '0;
      snk_ready = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 5);
      rst       = (cyc == rst_at);
      #1;
      if (rst_at > 0 && cyc == rst_at + 1) begin
        checks++;
        act = {busy, done, snk_valid, mmio_r_w, mmio_addr, mmio_wdata};
        if (act !== '0 || src_ready !== 1'b0 || snk_data !== '0) begin
          errors++;
          $display("FAIL rst_outputs act=%h src_ready=%b snk_data=%h req=0",
                   act, src_ready, snk_data);
        end
        src_valid = 1'b0;
        return;
      end
      if (trace) begin
        exp = '0;
        if (cyc >= 1 && cyc <= 82) exp[83] = 1'b1;
        if (cyc == 83) exp[82] = 1'b1;
        if (cyc >= 67 && cyc <= 82) exp[81] = 1'b1;
        if (cyc >= 1 && cyc <= 16) begin
          exp[80]    = 1'b1;
          exp[79:64] = c_exp_addr(cyc - 1);
        end else if (cyc >= 17 && cyc <= 24) begin
          exp[80]    = 1'b1;
          exp[79:64] = 16'(16'h100 + (cyc - 17) * 8);
          exp[63:0]  = src_data;
        end else if (cyc >= 25 && cyc <= 32) begin
          exp[80]    = 1'b1;
          exp[79:64] = 16'h200;
          exp[63:0]  = src_data;
        end else if (cyc == 33) begin
          exp[80]    = 1'b1;
          exp[79:64] = 16'h400;
        end else if (cyc >= 66 && cyc <= 81) begin
          exp[79:64] = c_exp_addr(cyc - 66);
        end
        act = {busy, done, snk_valid, mmio_r_w, mmio_addr, mmio_wdata};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL trace cyc=%0d act=%h req=%h", cyc, act, exp);
        end
      end
      if (src_ready) begin
        checks++;
        if (src_valid) begin
          ea = (sbeat < DIM) ? 16'(16'h100 + sbeat * 8) : 16'h200;
          if (mmio_r_w !== 1'b1 || mmio_addr !== ea ||
              mmio_wdata !== src_data) begin
            errors++;
            $display("FAIL load_write cyc=%0d rw=%b addr=%h req_addr=%h",
                     cyc, mmio_r_w, mmio_addr, ea);
          end
          void'(src_q.pop_front());
          sbeat++;
        end else if (mmio_r_w !== 1'b0) begin
          errors++;
          $display("FAIL load_idle cyc=%0d rw=%b req=0", cyc, mmio_r_w);
        end
      end
      if (holding) begin
        checks++;
        if (snk_valid !== 1'b1 || snk_data !== held) begin
          errors++;
          $display("FAIL snk_hold cyc=%0d data=%h req=%h", cyc, snk_data,
                   held);
        end
      end
      holding = snk_valid && !snk_ready;
      held    = snk_data;
      if (snk_valid && snk_ready) begin
        checks++;
        beats++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL snk_extra cyc=%0d data=%h req=none", cyc, snk_data);
        end else begin
          w = exp_q.pop_front();
          if (snk_data !== w) begin
            errors++;
            $display("FAIL snk_data cyc=%0d data=%h req=%h", cyc,
                     snk_data, w);
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    src_valid = 1'b0;
    checks++;
    if (done_cyc < 0 || beats != NW || exp_q.size() != 0) begin
      errors++;
      $display("FAIL job_end done_cyc=%0d beats=%0d left=%0d req_beats=%0d",
               done_cyc, beats, exp_q.size(), NW);
    end
  endtask

  task automatic check_done(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s done_cycle=%0d req=%0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    logic [83:0] act;
    rst       = 1'b1;
    go        = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    snk_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    act = {busy, done, snk_valid, mmio_r_w, mmio_addr, mmio_wdata};
    checks++;
    if (act !== '0 || src_ready !== 1'b0 || snk_data !== '0) begin
      errors++;
      $display("FAIL reset_state act=%h src_ready=%b req=0", act, src_ready);
    end
    src_valid = 1'b1;
    src_data  = 64'hdead_beef_0123_4567;
    #1;
    checks++;
    if (src_ready !== 1'b0 || mmio_r_w !== 1'b0 || mmio_wdata !== '0) begin
      errors++;
      $display("FAIL reset_src rdy=%b rw=%b wd=%h req=0", src_ready,
               mmio_r_w, mmio_wdata);
    end
    src_valid = 1'b0;
    src_data  = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_trace();
    int dc;
    load_job(0);
    run_job(1'b0, 0, 0, 0, 1'b1, dc);
    if (dc != -1) check_done("trace", dc, 83);
  endtask

  task automatic test_second_job();
    int dc;
    load_job(0);
    run_job(1'b0, 0, 0, 0, 1'b0, dc);
    check_done("second_job", dc, 83);
  endtask

  task automatic test_random_data();
    int dc;
    for (int n = 0; n < 2; n++) begin
      load_job(1);
      run_job(1'b0, 0, 0, 0, 1'b0, dc);
      check_done("random_data", dc, 83);
    end
  endtask

  task automatic test_src_toggle();
    int dc;
    load_job(1);
    run_job(1'b1, 0, 0, 0, 1'b0, dc);
    check_done("src_toggle", dc, 98);
  endtask

  task automatic test_snk_stall();
    int dc;
    load_job(1);
    run_job(1'b0, 70, 0, 0, 1'b0, dc);
    check_done("snk_stall", dc, 88);
  endtask

  task automatic test_go_in_wait();
    int dc;
    load_job(1);
    run_job(1'b0, 0, 40, 0, 1'b0, dc);
    check_done("go_in_wait", dc, 83);
  endtask

  task automatic test_go_on_done();
    int dc;
    load_job(0);
    run_job(1'b0, 0, 0, 0, 1'b0, dc);
    check_done("go_on_done_job", dc, 83);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || mmio_r_w !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL go_on_done i=%0d busy=%b rw=%b done=%b req=0", i,
                 busy, mmio_r_w, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_load_b();
    int dc;
    load_job(1);
    run_job(1'b0, 0, 0, 28, 1'b0, dc);
    @(negedge clk);
    load_job(1);
    run_job(1'b0, 0, 0, 0, 1'b0, dc);
    check_done("rst_fresh_job", dc, 83);
  endtask

  initial begin
    test_reset();
    test_trace();
    test_second_job();
    test_random_data();
    test_src_toggle();
    test_snk_stall();
    test_go_in_wait();
    test_go_on_done();
    test_rst_load_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
